// File: rtl/exp_table_reader_pkg.sv
// Shared table geometry and reader state encodings, so producer and reader agree
// on word width and depth.
package exp_table_reader_pkg;

  localparam int unsigned DEF_DATA_W = 18;  // 4 integer + 14 fraction bits, unsigned
  localparam int unsigned DEF_LOGT   = 9;
  localparam int unsigned DEF_T_MAX  = 511;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

endpackage

// File: rtl/exp_table_reader_if.sv
// Producer/consumer bundle for the exp table reader: fill port, read port and status.
interface exp_table_reader_if
  import exp_table_reader_pkg::*;
#(
  parameter int unsigned logT   = DEF_LOGT,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] iData;
  logic [logT-1:0]   iAddr;
  logic              iValid;
  logic              iDone;
  logic              iClear;
  logic              iRdEn;
  logic [logT-1:0]   iRdAddr;
  logic [DATA_W-1:0] oRdData;
  logic              oRdValid;
  logic              oReady;
  logic              oBusy;
  logic              oError;
  logic [logT:0]     oCount;

  modport master (
    output iData, iAddr, iValid, iDone, iClear, iRdEn, iRdAddr,
    input  oRdData, oRdValid, oReady, oBusy, oError, oCount
  );

  modport slave (
    input  iData, iAddr, iValid, iDone, iClear, iRdEn, iRdAddr,
    output oRdData, oRdValid, oReady, oBusy, oError, oCount
  );

endinterface

// File: rtl/ram_sdp_18.sv
// Simple dual-port table RAM: one write port, one registered read port, no reset.
module ram_sdp_18
  import exp_table_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_LOGT,
  parameter int unsigned DEPTH  = DEF_T_MAX + 1,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/exp_table_reader.sv
// Exp lookup table reader: accepts a strictly in-order fill from a producer, then
// serves pipelined 2-cycle reads once the table is complete.
module exp_table_reader
  import exp_table_reader_pkg::*;
#(
  parameter int unsigned logT   = DEF_LOGT,
  parameter int unsigned t_max  = DEF_T_MAX,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic CLK,
  input  logic RSTN,
  exp_table_reader_if.slave bus
);

  localparam logic [logT:0] FULL_CNT = (logT+1)'(t_max + 1);
  localparam logic [logT:0] CNT_ONE  = (logT+1)'(1);

  logic [1:0]        state, state_n;
  logic [logT:0]     count, count_n;
  logic              wr_en;
  logic              rd_acc;
  logic              rd_v1;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  // Write is resolved before the iDone count check so a final word and iDone may share a cycle.
  always_comb begin
    state_n = state;
    count_n = count;
    wr_en   = 1'b0;
    if (bus.iClear) begin
      state_n = ST_EMPTY;
      count_n = '0;
    end else begin
      case (state)
        ST_EMPTY, ST_FILL: begin
          if (bus.iValid) begin
            if ({1'b0, bus.iAddr} == count) begin
              wr_en   = 1'b1;
              count_n = count + CNT_ONE;
              state_n = ST_FILL;
            end else begin
              state_n = ST_ERR;
            end
          end
          // iDone in EMPTY is a stale level from the previous run
          if (state == ST_FILL && bus.iDone && state_n != ST_ERR)
            state_n = (count_n == FULL_CNT) ? ST_FULL : ST_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state <= ST_EMPTY;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  assign rd_acc = bus.iRdEn && (state == ST_FULL);

  ram_sdp_18 #(
    .ADDR_W (logT),
    .DEPTH  (t_max + 1),
    .DATA_W (DATA_W)
  ) u_ram (
    .CLK   (CLK),
    .we    (wr_en),
    .waddr (bus.iAddr),
    .wdata (bus.iData),
    .re    (rd_acc),
    .raddr (bus.iRdAddr),
    .rdata (ram_q)
  );

  // Read pipeline ignores iClear so that already-accepted reads still complete.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rd_v1    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_v1    <= rd_acc;
      rd_valid <= rd_v1;
      if (rd_v1) rd_data <= ram_q;
    end
  end

  assign bus.oRdData  = rd_data;
  assign bus.oRdValid = rd_valid;
  assign bus.oReady   = (state == ST_FULL);
  assign bus.oBusy    = (state == ST_FILL);
  assign bus.oError   = (state == ST_ERR);
  assign bus.oCount   = count;

endmodule

// File: tb/tb_exp_table_reader.sv
// Scenario bench for exp_table_reader; read results are checked against a
// reference table through a latency-tagged scoreboard.
module tb_exp_table_reader;

  localparam int LOGT = 9;
  localparam int TMAX = 511;
  localparam int DW   = 18;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  logic CLK;
  logic RSTN;
  int   cyc;
  int   n_checks;
  int   n_pass;

  logic [DW-1:0] model [TMAX+1];
  rd_exp_t       sb [$];

  exp_table_reader_if #(.logT(LOGT), .DATA_W(DW)) bus ();

  exp_table_reader #(.logT(LOGT), .t_max(TMAX), .DATA_W(DW)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc++;

  // Every oRdValid must match the oldest outstanding read, on its due cycle.
  always @(negedge CLK) begin
    rd_exp_t e;
    if (bus.oRdValid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL rd_unexpected: oRdValid=1 data=%h at cycle %0d, required no read", bus.oRdData, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.oRdData !== e.data || cyc !== e.due)
          $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d", bus.oRdData, cyc, e.data, e.due);
        else
          n_pass++;
      end
    end else if (sb.size() > 0 && sb[0].due < cyc) begin
      n_checks++;
      $display("FAIL rd_missing: no oRdValid by cycle %0d, required %h at cycle %0d", cyc, sb[0].data, sb[0].due);
      void'(sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.iData = '0; bus.iAddr = '0; bus.iValid = 1'b0; bus.iDone = 1'b0;
    bus.iClear = 1'b0; bus.iRdEn = 1'b0; bus.iRdAddr = '0;
  endtask

  task automatic fill_range(input int lo, input int hi, input bit done_last);
    logic [DW-1:0] d;
    for (int a = lo; a <= hi; a++) begin
      d = DW'($urandom);
      bus.iValid = 1'b1;
      bus.iAddr  = LOGT'(a);
      bus.iData  = d;
      bus.iDone  = done_last && (a == hi);
      model[a]   = d;
      tick();
    end
    bus.iValid = 1'b0;
    bus.iDone  = 1'b0;
  endtask

  task automatic clear_table();
    bus.iClear = 1'b1;
    tick();
    bus.iClear = 1'b0;
  endtask

  task automatic read_req(input int a, input bit expect_data);
    rd_exp_t e;
    bus.iRdEn   = 1'b1;
    bus.iRdAddr = LOGT'(a);
    if (expect_data) begin
      e.data = model[a];
      e.due  = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic check_status(input string name, input logic rdy, input logic busy,
                              input logic err, input int cnt);
    n_checks++;
    if (bus.oReady !== rdy || bus.oBusy !== busy || bus.oError !== err || bus.oCount !== (LOGT+1)'(cnt))
      $display("FAIL %s: ready/busy/error/count=%b/%b/%b/%0d, required %b/%b/%b/%0d",
               name, bus.oReady, bus.oBusy, bus.oError, bus.oCount, rdy, busy, err, cnt);
    else
      n_pass++;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s: %0d reads outstanding, required 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    idle_inputs();
    bus.iClear = 1'b1;
    repeat (3) tick();
    check_status("reset_status", 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (bus.oRdValid !== 1'b0 || bus.oRdData !== '0)
      $display("FAIL reset_read: valid/data=%b/%h, required 0/0", bus.oRdValid, bus.oRdData);
    else n_pass++;
    bus.iClear = 1'b0;
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_full_fill();
    fill_range(0, 255, 1'b0);
    check_status("fill_midway", 1'b0, 1'b1, 1'b0, 256);
    fill_range(256, TMAX, 1'b0);
    bus.iDone = 1'b1;
    tick();
    bus.iDone = 1'b0;
    check_status("fill_done_full", 1'b1, 1'b0, 1'b0, 512);
    bus.iValid = 1'b1; bus.iAddr = '0; bus.iData = ~model[0];
    tick();
    bus.iValid = 1'b0;
    check_status("full_ignores_write", 1'b1, 1'b0, 1'b0, 512);
  endtask

  task automatic test_back_to_back();
    read_req(0, 1'b1);   tick();
    read_req(TMAX, 1'b1); tick();
    read_req(37, 1'b1);  tick();
    bus.iRdEn = 1'b0;
    wait_drain("b2b_drain");
    repeat (2) tick();
    n_checks++;
    if (bus.oRdValid !== 1'b0 || bus.oRdData !== model[37])
      $display("FAIL rd_hold: valid/data=%b/%h, required 0/%h", bus.oRdValid, bus.oRdData, model[37]);
    else n_pass++;
  endtask

  task automatic test_repeat_error();
    clear_table();
    check_status("clear_to_empty", 1'b0, 1'b0, 1'b0, 0);
    fill_range(0, 5, 1'b0);
    bus.iValid = 1'b1; bus.iAddr = LOGT'(5); bus.iData = ~model[5];
    tick();
    check_status("repeat_addr_err", 1'b0, 1'b0, 1'b1, 6);
    bus.iAddr = LOGT'(6);
    tick();
    bus.iValid = 1'b0;
    check_status("err_sticky", 1'b0, 1'b0, 1'b1, 6);
    clear_table();
    check_status("err_clear", 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_done_count();
    fill_range(0, 300, 1'b0);
    bus.iDone = 1'b1;
    tick();
    check_status("short_done_err", 1'b0, 1'b0, 1'b1, 301);
    bus.iClear = 1'b1;
    tick();
    bus.iClear = 1'b0;
    read_req(3, 1'b0);
    tick();
    check_status("stale_done_empty", 1'b0, 1'b0, 1'b0, 0);
    bus.iDone  = 1'b0;
    bus.iRdEn  = 1'b0;
    fill_range(0, 2, 1'b0);
    read_req(1, 1'b0);
    tick();
    bus.iRdEn = 1'b0;
    repeat (3) tick();
    check_status("read_in_fill_dropped", 1'b0, 1'b1, 1'b0, 3);
    fill_range(3, TMAX, 1'b1);
    check_status("last_write_with_done", 1'b1, 1'b0, 1'b0, 512);
  endtask

  task automatic test_clear_during_read();
    read_req(100, 1'b1);
    tick();
    bus.iRdEn  = 1'b0;
    bus.iClear = 1'b1;
    tick();
    bus.iClear = 1'b0;
    check_status("clear_after_read", 1'b0, 1'b0, 1'b0, 0);
    wait_drain("clear_read_drain");
  endtask

  task automatic test_reset_mid();
    fill_range(0, TMAX, 1'b1);
    check_status("refill_full", 1'b1, 1'b0, 1'b0, 512);
    read_req(7, 1'b0);
    tick();
    bus.iRdEn = 1'b0;
    RSTN = 1'b0;
    tick();
    RSTN = 1'b1;
    repeat (3) tick();
    check_status("reset_mid_read", 1'b0, 1'b0, 1'b0, 0);
    fill_range(0, 199, 1'b0);
    check_status("count_200", 1'b0, 1'b1, 1'b0, 200);
    RSTN = 1'b0;
    bus.iValid = 1'b1; bus.iAddr = LOGT'(200); bus.iData = '1;
    tick();
    bus.iValid = 1'b0;
    check_status("reset_mid_fill", 1'b0, 1'b0, 1'b0, 0);
    n_checks++;
    if (bus.oRdValid !== 1'b0 || bus.oRdData !== '0)
      $display("FAIL reset_mid_rd: valid/data=%b/%h, required 0/0", bus.oRdValid, bus.oRdData);
    else n_pass++;
    RSTN = 1'b1;
    tick();
    fill_range(0, TMAX, 1'b1);
    check_status("refill_after_reset", 1'b1, 1'b0, 1'b0, 512);
    read_req(200, 1'b1); tick();
    read_req(0, 1'b1);   tick();
    bus.iRdEn = 1'b0;
    wait_drain("final_drain");
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_full_fill();
    test_back_to_back();
    test_repeat_error();
    test_done_count();
    test_clear_during_read();
    test_reset_mid();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exp_table_reader.md
EXP_TABLE_READER -- requirements
Module: exp_table_reader

Interface
REQ-001 The block SHALL have parameter logT, default 9, meaning the table address width.
REQ-002 The block SHALL have parameter t_max, default 511, meaning the last table index (table depth t_max+1).
REQ-003 The block SHALL have parameter DATA_W, default 18, meaning the table word width (4 int, 14 frac, unsigned).
REQ-004 The block SHALL have the port: CLK  in  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL have the port: RSTN  in  1  reset, synchronous, active-low.
REQ-006 The block SHALL have the port: iData  in  DATA_W  table word from the producer.
REQ-007 The block SHALL have the port: iAddr  in  logT  table index of iData.
REQ-008 The block SHALL have the port: iValid  in  1  iData/iAddr valid this cycle.
REQ-009 The block SHALL have the port: iDone  in  1  producer-finished level.
REQ-010 The block SHALL have the port: iClear  in  1  discard the table and return to empty.
REQ-011 The block SHALL have the port: iRdEn  in  1  read request.
REQ-012 The block SHALL have the port: iRdAddr  in  logT  read index.
REQ-013 The block SHALL have the port: oRdData  out  DATA_W  read result.
REQ-014 The block SHALL have the port: oRdValid  out  1  oRdData valid.
REQ-015 The block SHALL have the port: oReady  out  1  table complete, reads are served.
REQ-016 The block SHALL have the port: oBusy  out  1  fill in progress.
REQ-017 The block SHALL have the port: oError  out  1  sticky fill-protocol error.
REQ-018 The block SHALL have the port: oCount  out  logT+1  words accepted so far.

Function
REQ-019 The state machine SHALL have states EMPTY, FILL, FULL and ERR; oBusy=(FILL), oReady=(FULL), oError=(ERR).
REQ-020 In EMPTY or FILL, iValid with iAddr==oCount SHALL write iData to RAM[iAddr] and increment oCount; EMPTY SHALL go to FILL on the first write.
REQ-021 In EMPTY or FILL, iValid with iAddr!=oCount (gap, repeat or out of order) SHALL go to ERR and SHALL NOT write.
REQ-022 In FILL, iDone SHALL go to FULL when oCount (after any same-cycle write) equals t_max+1, and to ERR otherwise.
REQ-023 When iValid and iDone are both high in one cycle, the write SHALL be evaluated first and the count check second.
REQ-024 iDone in EMPTY SHALL be ignored, because it is a level the producer may still be holding from the previous run.
REQ-025 In FULL, iValid SHALL be ignored: no write, no error, oCount unchanged.
REQ-026 iClear in any state SHALL move the block to EMPTY with oCount=0 on the next edge, leave RAM contents unchanged, and take priority over all other inputs that cycle.
REQ-027 ERR SHALL be left only by iClear or reset.
REQ-028 A read request SHALL be accepted only when iRdEn=1 and state is FULL; requests in any other state SHALL be dropped with no oRdValid.
REQ-029 Read latency SHALL be exactly 2 cycles: request at edge N gives oRdValid=1 and oRdData=RAM[iRdAddr] after edge N+2.
REQ-030 Reads SHALL be fully pipelined, one per cycle, with no back-pressure.
REQ-031 Reads already accepted when iClear arrives SHALL still complete.
REQ-032 oRdData SHALL hold its last value while oRdValid=0.
REQ-033 iRdAddr>t_max SHALL return undefined data with oRdValid=1, and this SHALL NOT raise an error.
REQ-034 The 2-cycle read SHALL be composed of a registered RAM read followed by an output register.
REQ-035 Read and write SHALL never target the table in the same state, so no read-during-write bypass is required.

Reset
REQ-036 RSTN=0 at a rising edge SHALL set: state EMPTY, oCount=0, oRdValid=0, oRdData=0, the read pipeline cleared, oError/oBusy/oReady=0.
REQ-037 Reset SHALL dominate iClear, and RAM contents SHALL NOT be reset.
REQ-038 Reset mid-fill or mid-read SHALL abort all activity with no spurious oRdValid afterwards.

Structure
REQ-039 The shared package SHALL hold DATA_W, logT, t_max defaults and the state encoding constants, so the producer and reader agree on width and depth.
REQ-040 A single sub-module SHALL be used: ram_sdp_18, a simple dual-port (t_max+1)xDATA_W RAM with one write port and one registered read port.

Verification
REQ-041 The bench SHALL drive a full fill with addresses 0..511 one per cycle, then iDone -> oReady=1, oCount=512, oError=0.
REQ-042 The bench SHALL drive FULL with iRdEn on addresses 0, 511, 37 on consecutive cycles -> oRdValid high for 3 consecutive cycles starting 2 cycles later, with data equal to the words written.
REQ-043 The bench SHALL drive a fill with address 5 repeated -> ERR at that edge, oError=1, then iClear -> EMPTY, oError=0.
REQ-044 The bench SHALL drive a fill of 0..300 then iDone -> ERR; a separate fill with write 511 and iDone in the same cycle -> FULL.
REQ-045 The bench SHALL issue reads in EMPTY/FILL -> no oRdValid; then, in FULL, a read with iClear the next cycle -> that read still returns valid data.
REQ-046 The bench SHALL assert RSTN=0 mid-fill at count 200 -> all outputs at reset values next cycle, and a refill from 0 -> FULL.
